varredura_display: RTL and testbench

Two-digit multiplexed 7-segment driver for the 0–99 result path. It captures a 7-bit binary value on a load strobe and splits it internally into tens and units BCD digits. It then time-multiplexes the two digits onto one shared active-low segment bus at a parameterised refresh rate. It sits directly downstream of the units-digit extraction logic and is the last stage before the board's display pins.

---
 rtl/varredura_display.sv | 111 +++++++++++
 tb/tb_varredura_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/varredura_display.sv
// Two-digit multiplexed 7-segment driver: captures a 0..127 value, splits it into
// tens/units BCD and scans both digits onto one active-low segment bus.
module varredura_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] valor,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       ovf
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [6:0]       v_q, v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             ovf_q, ovf_d;

    logic [3:0] tens;
    logic [3:0] units;
    logic [6:0] tens_x10;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Compare chain saturates tens at 9; values above 99 are shown as a dash anyway.
    always_comb begin
        tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (v_q >= 7'(i * 10)) begin
                tens = 4'(i);
            end
        end
        tens_x10 = {tens, 3'b000} + {2'b00, tens, 1'b0};
        units    = 4'(v_q - tens_x10);
    end

    always_comb begin
        v_d   = load ? valor : v_q;
        cnt_d = cnt_q + 1'b1;
        sel_d = sel_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end

        ovf_d = 1'b0;
        seg_d = enc(units);
        an_d  = 2'b10;
        if (v_q > 7'd99) begin
            ovf_d = 1'b1;
            seg_d = SEG_DASH;
            an_d  = sel_q ? 2'b01 : 2'b10;
        end else if (sel_q) begin
            if (tens != 4'd0) begin
                seg_d = enc(tens);
                an_d  = 2'b01;
            end else begin
                seg_d = SEG_BLANK;
                an_d  = 2'b11;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cnt_q <= '0;
            sel_q <= 1'b0;
            seg_q <= SEG_BLANK;
            an_q  <= 2'b11;
            ovf_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            ovf_q <= ovf_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_varredura_display.sv
// Table-driven bench for varredura_display: a REFRESH_DIV=4 instance walks the
// scan/load/overflow sequence, a REFRESH_DIV=1 instance checks per-cycle alternation.
module tb_varredura_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [1:0] AU = 2'b10;
    localparam logic [1:0] AT = 2'b01;
    localparam logic [1:0] AX = 2'b11;

    typedef struct {
        logic       load;
        logic [6:0] valor;
        logic [6:0] seg;
        logic [1:0] an;
        logic       ovf;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [6:0] valor;
    logic [6:0] seg4, seg1;
    logic [1:0] an4, an1;
    logic       ovf4, ovf1;

    int compared   = 0;
    int mismatched = 0;
    vec_t vecs[$];

    varredura_display #(.REFRESH_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load), .valor(valor),
        .seg(seg4), .an(an4), .ovf(ovf4)
    );

    varredura_display #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .valor(valor),
        .seg(seg1), .an(an1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic l, input logic [6:0] val, input logic [6:0] s,
                          input logic [1:0] a, input logic o);
        vec_t r;
        r.load = l; r.valor = val; r.seg = s; r.an = a; r.ovf = o;
        vecs.push_back(r);
    endtask

    task automatic applyStimulus(input logic l, input logic [6:0] val);
        load  = l;
        valor = val;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] s_act, input logic [1:0] a_act,
                               input logic o_act, input logic [6:0] s_exp, input logic [1:0] a_exp,
                               input logic o_exp);
        compared++;
        if (s_act !== s_exp || a_act !== a_exp || o_act !== o_exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got seg=%b an=%b ovf=%b, want seg=%b an=%b ovf=%b",
                     name, s_act, a_act, o_act, s_exp, a_exp, o_exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        valor = 7'd0;

        // Idle scan: units shows 0, tens blanked.
        for (int i = 0; i < 4; i++) addVec(0, 0, S0, AU, 0);
        for (int i = 0; i < 4; i++) addVec(0, 0, BL, AX, 0);
        addVec(0, 0, S0, AU, 0);
        // Load 47 mid units slot.
        addVec(1, 47, S0, AU, 0);
        addVec(0, 0, S7, AU, 0);
        addVec(0, 0, S7, AU, 0);
        for (int i = 0; i < 4; i++) addVec(0, 0, S4, AT, 0);
        addVec(0, 0, S7, AU, 0);
        // Load 5: tens blanked.
        addVec(1, 5, S7, AU, 0);
        addVec(0, 0, S5, AU, 0);
        addVec(0, 0, S5, AU, 0);
        // Load 10 at start of tens slot.
        addVec(1, 10, BL, AX, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, S1, AT, 0);
        addVec(0, 0, S0, AU, 0);
        // Load 99.
        addVec(1, 99, S0, AU, 0);
        addVec(0, 0, S9, AU, 0);
        addVec(0, 0, S9, AU, 0);
        // Load 100 during tens slot.
        addVec(1, 100, S9, AT, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, DS, AT, 1);
        // Load 127, then 0 clears ovf one cycle later.
        addVec(1, 127, DS, AU, 1);
        addVec(0, 0, DS, AU, 1);
        addVec(1, 0, DS, AU, 1);
        addVec(0, 0, S0, AU, 0);
        for (int i = 0; i < 4; i++) addVec(0, 0, BL, AX, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, S0, AU, 0);
        // Load 36 on the wrap edge: new value lands on the tens digit.
        addVec(1, 36, S0, AU, 0);
        addVec(0, 0, S3, AT, 0);
        addVec(0, 0, S3, AT, 0);

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset4", seg4, an4, ovf4, BL, AX, 1'b0);
        checkOutput("reset1", seg1, an1, ovf1, BL, AX, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].load, vecs[i].valor);
            checkOutput($sformatf("vec%0d", i), seg4, an4, ovf4, vecs[i].seg, vecs[i].an, vecs[i].ovf);
        end

        // Mid-tens-slot reset: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset", seg4, an4, ovf4, BL, AX, 1'b0);
        applyStimulus(0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0);
            checkOutput($sformatf("restart_u%0d", i), seg4, an4, ovf4, S0, AU, 1'b0);
        end
        applyStimulus(0, 0);
        checkOutput("restart_t", seg4, an4, ovf4, BL, AX, 1'b0);

        // REFRESH_DIV=1 alternation with 36.
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        applyStimulus(1, 36);
        checkOutput("div1_first", seg1, an1, ovf1, S0, AU, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0);
            if (i % 2 == 0)
                checkOutput($sformatf("div1_t%0d", i), seg1, an1, ovf1, S3, AT, 1'b0);
            else
                checkOutput($sformatf("div1_u%0d", i), seg1, an1, ovf1, S6, AU, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
